// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and legal parameter ranges.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK_WAIT
   } state_t;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_EVEN = 1;
   localparam int unsigned PAR_ODD  = 2;

   localparam int unsigned DATA_BITS_MIN  = 5;
   localparam int unsigned DATA_BITS_MAX  = 9;
   localparam int unsigned OVERSAMPLE_MIN = 8;
   localparam int unsigned OVERSAMPLE_MAX = 32;

   function automatic bit cfg_legal(input int unsigned data_bits, input int unsigned oversample,
                                    input int unsigned parity, input int unsigned stop_bits,
                                    input int unsigned sync_stages);
      return (data_bits >= DATA_BITS_MIN) && (data_bits <= DATA_BITS_MAX) &&
             (oversample >= OVERSAMPLE_MIN) && (oversample <= OVERSAMPLE_MAX) &&
             (oversample % 2 == 0) && (parity <= PAR_ODD) &&
             (stop_bits >= 1) && (stop_bits <= 2) && (sync_stages >= 2);
   endfunction

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous, idle-high input; resets to 1.
module uart_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_ff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_ff <= '1;
      else     r_ff <= {r_ff[STAGES-2:0], i_d};
   end

   assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with valid/ready holding register.
// Build option UART_RX_MAJORITY_EN: each bit is a 3-sample majority vote around mid-bit.
module uart_rx_param #(
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned PARITY      = 0,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 baud_tick,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   import uart_pkg::*;

   localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned BCNT_W = 4;
   localparam logic [TCNT_W-1:0] T_MID_START = TCNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TCNT_W-1:0] T_MID       = TCNT_W'(OVERSAMPLE - 1);
   localparam logic [BCNT_W-1:0] B_LAST_DATA = BCNT_W'(DATA_BITS - 1);
   localparam logic [BCNT_W-1:0] B_LAST_STOP = BCNT_W'(STOP_BITS - 1);
   localparam bit HAS_PAR = (PARITY != PAR_NONE);
   localparam bit ODD_PAR = (PARITY == PAR_ODD);

   if (!cfg_legal(DATA_BITS, OVERSAMPLE, PARITY, STOP_BITS, SYNC_STAGES)) begin : g_cfg_check
      $error("uart_rx_param: illegal parameter combination");
   end

   logic                 w_rx;
   logic                 w_bit;
   state_t               r_state;
   logic [TCNT_W-1:0]    r_tcnt;
   logic [BCNT_W-1:0]    r_bcnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_fe;
   logic                 r_pe;
   logic                 r_stop_one;
   logic                 r_done;
   logic                 r_busy;
   logic [DATA_BITS-1:0] r_data_out;
   logic                 r_valid;
   logic                 r_frame_err;
   logic                 r_parity_err;
   logic                 r_overrun;

   uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (rx_in),
      .o_q (w_rx)
   );

`ifdef UART_RX_MAJORITY_EN
   // Last two tick samples; with the live sample they form the vote window ending at mid-bit.
   logic [1:0] r_hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_hist <= 2'b11;
      else if (baud_tick) r_hist <= {r_hist[0], w_rx};
   end

   assign w_bit = maj3({r_hist, w_rx});
`else
   assign w_bit = w_rx;
`endif

   // Frame FSM: all progress is gated by baud_tick; r_done pulses one clk at frame completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_tcnt     <= '0;
         r_bcnt     <= '0;
         r_shift    <= '0;
         r_fe       <= 1'b0;
         r_pe       <= 1'b0;
         r_stop_one <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (baud_tick) begin
            case (r_state)
               ST_IDLE: begin
                  if (!w_rx) begin
                     r_tcnt  <= '0;
                     r_busy  <= 1'b1;
                     r_state <= ST_START;
                  end
               end
               ST_START: begin
                  if (r_tcnt == T_MID_START) begin
                     if (w_bit) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                     end else begin
                        r_tcnt     <= '0;
                        r_bcnt     <= '0;
                        r_fe       <= 1'b0;
                        r_pe       <= 1'b0;
                        r_stop_one <= 1'b0;
                        r_state    <= ST_DATA;
                     end
                  end else begin
                     r_tcnt <= r_tcnt + TCNT_W'(1);
                  end
               end
               ST_DATA: begin
                  if (r_tcnt == T_MID) begin
                     r_tcnt  <= '0;
                     r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                     if (r_bcnt == B_LAST_DATA) begin
                        r_bcnt  <= '0;
                        r_state <= HAS_PAR ? ST_PARITY : ST_STOP;
                     end else begin
                        r_bcnt <= r_bcnt + BCNT_W'(1);
                     end
                  end else begin
                     r_tcnt <= r_tcnt + TCNT_W'(1);
                  end
               end
               ST_PARITY: begin
                  if (r_tcnt == T_MID) begin
                     r_tcnt  <= '0;
                     r_pe    <= ((^r_shift) ^ w_bit) != ODD_PAR;
                     r_state <= ST_STOP;
                  end else begin
                     r_tcnt <= r_tcnt + TCNT_W'(1);
                  end
               end
               ST_STOP: begin
                  if (r_tcnt == T_MID) begin
                     r_tcnt <= '0;
                     if (!w_bit) r_fe       <= 1'b1;
                     else        r_stop_one <= 1'b1;
                     if (r_bcnt == B_LAST_STOP) begin
                        r_bcnt  <= '0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        // An all-zero frame is a break: wait for the line to recover before rearming.
                        r_state <= ((r_shift == '0) && !r_stop_one && !w_bit) ? ST_BREAK_WAIT : ST_IDLE;
                     end else begin
                        r_bcnt <= r_bcnt + BCNT_W'(1);
                     end
                  end else begin
                     r_tcnt <= r_tcnt + TCNT_W'(1);
                  end
               end
               ST_BREAK_WAIT: begin
                  if (w_rx) r_state <= ST_IDLE;
               end
               default: begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Holding register: load on completion when free or being drained, else flag overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data_out   <= '0;
         r_valid      <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (r_done) begin
            if (!r_valid || data_ready) begin
               r_data_out   <= r_shift;
               r_frame_err  <= r_fe;
               r_parity_err <= r_pe;
               r_valid      <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && data_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_out   = r_data_out;
   assign data_valid = r_valid;
   assign frame_err  = r_frame_err;
   assign parity_err = r_parity_err;
   assign overrun    = r_overrun;
   assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: an 8N1 instance and an 8E1 instance against a frame-level model.
module tb_uart_rx_param;

   localparam int TICK_CLKS = 2;
   localparam int BIT_CLKS  = 16 * TICK_CLKS;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       baud_tick = 1'b0;
   logic       rx_a = 1'b1, rx_b = 1'b1;
   logic       rdy_a = 1'b1, rdy_b = 1'b1;
   logic [7:0] dout_a, dout_b;
   logic       v_a, fe_a, pe_a, ov_a, busy_a;
   logic       v_b, fe_b, pe_b, ov_b, busy_b;

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_a), .data_out(dout_a),
      .data_valid(v_a), .data_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a),
      .overrun(ov_a), .busy(busy_a));

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_b), .data_out(dout_b),
      .data_valid(v_b), .data_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b),
      .overrun(ov_b), .busy(busy_b));

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #1 baud_tick = ~baud_tick;
      end
   end

   typedef struct {
      logic [7:0] d;
      logic       fe;
      logic       pe;
      logic       drop;
   } exp_t;

   exp_t       q_a[$];
   exp_t       q_b[$];
   int         n_checks = 0;
   int         n_pass = 0;
   logic       prev_v[2], prev_x[2], prev_fe[2], prev_pe[2];
   logic [7:0] prev_d[2];
   int         vcnt[2], ocnt[2];
   logic [7:0] last_d[2];
   logic       last_fe[2], last_pe[2];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   task automatic pop_exp(input int w, output exp_t e, output bit ok);
      ok = 1'b0;
      if (w == 0 && q_a.size() != 0) begin e = q_a.pop_front(); ok = 1'b1; end
      if (w == 1 && q_b.size() != 0) begin e = q_b.pop_front(); ok = 1'b1; end
      check($sformatf("inst%0d_word_was_expected", w), 32'(ok), 32'd1);
   endtask

   // Per-instance comparison against the expected-frame queue.
   task automatic mon(input int w, input logic v, input logic [7:0] d, input logic fe,
                      input logic pe, input logic ov, input logic rdy);
      exp_t e;
      bit   ok;
      if (ov) begin
         ocnt[w]++;
         pop_exp(w, e, ok);
         if (ok) check($sformatf("inst%0d_overrun_on_dropped_frame", w), 32'(e.drop), 32'd1);
      end
      if (v && (!prev_v[w] || prev_x[w])) begin
         pop_exp(w, e, ok);
         if (ok) begin
            check($sformatf("inst%0d_delivered_not_dropped", w), 32'(e.drop), 32'd0);
            check($sformatf("inst%0d_data_out", w), 32'(d), 32'(e.d));
            check($sformatf("inst%0d_frame_err", w), 32'(fe), 32'(e.fe));
            check($sformatf("inst%0d_parity_err", w), 32'(pe), 32'(e.pe));
         end
         last_d[w]  = d;
         last_fe[w] = fe;
         last_pe[w] = pe;
      end
      if (v && prev_v[w] && !prev_x[w]) begin
         check($sformatf("inst%0d_held_word_stable", w), 32'({d, fe, pe}),
               32'({prev_d[w], prev_fe[w], prev_pe[w]}));
      end
      if (v) vcnt[w]++;
      prev_v[w]  = v;
      prev_x[w]  = v && rdy;
      prev_d[w]  = d;
      prev_fe[w] = fe;
      prev_pe[w] = pe;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         prev_v[i] = 1'b0; prev_x[i] = 1'b0; vcnt[i] = 0; ocnt[i] = 0;
         last_d[i] = 8'h00; last_fe[i] = 1'b0; last_pe[i] = 1'b0;
      end
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_v[0] = 1'b0;
            prev_v[1] = 1'b0;
         end else begin
            mon(0, v_a, dout_a, fe_a, pe_a, ov_a, rdy_a);
            mon(1, v_b, dout_b, fe_b, pe_b, ov_b, rdy_b);
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_rx(input int w, input logic b);
      if (w == 0) rx_a = b;
      else        rx_b = b;
   endtask

   task automatic send_bit(input int w, input logic b);
      set_rx(w, b);
      wait_clks(BIT_CLKS);
   endtask

   // Instance 1 carries an even-parity bit; the model derives fe/pe from the bits on the wire.
   task automatic send_frame(input int w, input logic [7:0] d, input logic par_bit,
                             input logic stop_b, input logic drop);
      exp_t e;
      e.d    = d;
      e.fe   = ~stop_b;
      e.pe   = (w == 1) ? ^{d, par_bit} : 1'b0;
      e.drop = drop;
      if (w == 0) q_a.push_back(e);
      else        q_b.push_back(e);
      send_bit(w, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(w, d[i]);
      if (w == 1) send_bit(w, par_bit);
      send_bit(w, stop_b);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data_out"}, 32'(dout_a), 32'd0);
      check({tag, "_flags"}, 32'({v_a, fe_a, pe_a, ov_a, busy_a}), 32'd0);
   endtask

   int   v0, o0;
   exp_t brk;

   initial begin
      wait_clks(5);
      check_all_zero("reset_a");
      check("reset_b_flags", 32'({dout_b, v_b, fe_b, pe_b, ov_b, busy_b}), 32'd0);
      rst = 1'b0;
      wait_clks(4);

      v0 = vcnt[0];
      send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0);
      wait_clks(2 * BIT_CLKS);
      check("a5_valid_one_clk", 32'(vcnt[0] - v0), 32'd1);
      check("a5_data", 32'(last_d[0]), 32'hA5);
      check("a5_errs", 32'({last_fe[0], last_pe[0]}), 32'd0);

      send_frame(1, 8'h07, 1'b0, 1'b1, 1'b0);
      wait_clks(BIT_CLKS);
      check("par07_bad_data", 32'(last_d[1]), 32'h07);
      check("par07_bad_pe", 32'(last_pe[1]), 32'd1);
      send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0);
      wait_clks(BIT_CLKS);
      check("par07_good_pe", 32'(last_pe[1]), 32'd0);

      v0 = vcnt[0];
      set_rx(0, 1'b0);
      wait_clks(4 * TICK_CLKS);
      check("glitch_busy_high", 32'(busy_a), 32'd1);
      set_rx(0, 1'b1);
      wait_clks(2 * BIT_CLKS);
      check("glitch_busy_low", 32'(busy_a), 32'd0);
      check("glitch_no_word", 32'(vcnt[0] - v0), 32'd0);
      send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0);
      wait_clks(BIT_CLKS);
      check("after_glitch_data", 32'(last_d[0]), 32'h3C);

      rdy_a = 1'b0;
      o0 = ocnt[0];
      send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0);
      send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
      wait_clks(BIT_CLKS);
      check("ovr_valid_held", 32'(v_a), 32'd1);
      check("ovr_data_kept", 32'(dout_a), 32'h11);
      check("ovr_one_pulse", 32'(ocnt[0] - o0), 32'd1);
      rdy_a = 1'b1;
      wait_clks(2);
      check("ovr_drain_clears_valid", 32'(v_a), 32'd0);

      v0 = vcnt[0];
      brk.d = 8'h00; brk.fe = 1'b1; brk.pe = 1'b0; brk.drop = 1'b0;
      q_a.push_back(brk);
      set_rx(0, 1'b0);
      wait_clks(30 * BIT_CLKS);
      check("break_one_word", 32'(vcnt[0] - v0), 32'd1);
      check("break_word", 32'({last_d[0], last_fe[0]}), 32'({8'h00, 1'b1}));
      check("break_not_busy", 32'(busy_a), 32'd0);
      set_rx(0, 1'b1);
      wait_clks(BIT_CLKS);
      send_frame(0, 8'h55, 1'b0, 1'b1, 1'b0);
      wait_clks(BIT_CLKS);
      check("after_break_data", 32'(last_d[0]), 32'h55);

      rdy_a = 1'b0;
      send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0);
      wait_clks(BIT_CLKS);
      check("pre_reset_held", 32'(v_a), 32'd1);
      send_bit(0, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
      wait_clks(BIT_CLKS / 2);
      check("mid_data_busy", 32'(busy_a), 32'd1);
      rst = 1'b1;
      set_rx(0, 1'b1);
      #1;
      check_all_zero("midframe_reset");
      wait_clks(3);
      rst = 1'b0;
      rdy_a = 1'b1;
      wait_clks(BIT_CLKS);
      send_frame(0, 8'h81, 1'b0, 1'b1, 1'b0);
      wait_clks(2 * BIT_CLKS);
      check("after_reset_data", 32'(last_d[0]), 32'h81);
      check("after_reset_errs", 32'({last_fe[0], last_pe[0]}), 32'd0);

      check("queue_a_drained", 32'(q_a.size()), 32'd0);
      check("queue_b_drained", 32'(q_b.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
